// File: rtl/screen_buf_sched.sv
// Screen-buffer write scheduler.
// Arbitrates the single screen-buffer write port between a host (one character
// at a time, req/ack handshake) and a bulk filler (random refill or blanking).
// A frame counter triggers periodic refills; a sticky clear request wins over
// a refill on the next vsync seen in IDLE.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   vsync                             one-cycle frame-start pulse
//   clear_req                         one-cycle request to blank the screen
//   host_req/x/y/c, host_ack          host single-character write handshake
//   fill_we/x/y/c                     write stream from the filler
//   refresh, zero_buf                 filler restart pulse, blank-char select
//   buf_we/x/y/c                      screen-buffer write port
//   busy                              high while an operation is in progress
module screen_buf_sched #(
    parameter int unsigned width              = 128,
    parameter int unsigned height             = 48,
    parameter int unsigned char_width         = 8,
    parameter int unsigned frames_per_refresh = 60
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       vsync,
    input  logic                       clear_req,
    input  logic                       host_req,
    input  logic [$clog2(width)-1:0]   host_x,
    input  logic [$clog2(height)-1:0]  host_y,
    input  logic [char_width-1:0]      host_c,
    output logic                       host_ack,
    input  logic                       fill_we,
    input  logic [$clog2(width)-1:0]   fill_x,
    input  logic [$clog2(height)-1:0]  fill_y,
    input  logic [char_width-1:0]      fill_c,
    output logic                       refresh,
    output logic                       zero_buf,
    output logic                       buf_we,
    output logic [$clog2(width)-1:0]   buf_x,
    output logic [$clog2(height)-1:0]  buf_y,
    output logic [char_width-1:0]      buf_c,
    output logic                       busy
);

    localparam int unsigned XWidth  = $clog2(width);
    localparam int unsigned YWidth  = $clog2(height);
    localparam int unsigned WdLimit = width * height + 4;
    localparam int unsigned WdWidth = $clog2(WdLimit);

    typedef enum logic [1:0] {StIdle, StStart, StFill, StClear} state_e;

    state_e               state_q, state_d;
    logic                 mode_clear_q, mode_clear_d;
    logic [7:0]           fcnt_q, fcnt_d;
    logic                 clr_pend_q, clr_pend_d;
    logic                 refill_due_q, refill_due_d;
    logic                 ack_q;
    logic                 fill_we_q, fill_we_d;
    logic [WdWidth-1:0]   wd_q, wd_d;
    logic                 en_q;
    logic                 start_op;
    logic                 grant;

    always_comb begin
        state_d      = state_q;
        mode_clear_d = mode_clear_q;
        fcnt_d       = fcnt_q;
        clr_pend_d   = clr_pend_q;
        refill_due_d = refill_due_q;
        fill_we_d    = 1'b0;
        wd_d         = wd_q;
        start_op     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (vsync) begin
                    if (fcnt_q == 8'(frames_per_refresh - 1)) begin
                        fcnt_d       = 8'd0;
                        refill_due_d = 1'b1;
                    end else begin
                        fcnt_d = fcnt_q + 8'd1;
                    end
                    // Clear wins and also discards any refill that was due.
                    if (clr_pend_q) begin
                        state_d      = StStart;
                        mode_clear_d = 1'b1;
                        clr_pend_d   = 1'b0;
                        refill_due_d = 1'b0;
                        start_op     = 1'b1;
                    end else if (refill_due_d) begin
                        state_d      = StStart;
                        mode_clear_d = 1'b0;
                        refill_due_d = 1'b0;
                        start_op     = 1'b1;
                    end
                end
            end
            StStart: begin
                state_d = mode_clear_q ? StClear : StFill;
                wd_d    = '0;
            end
            StFill, StClear: begin
                fill_we_d = fill_we;
                wd_d      = wd_q + 1'b1;
                // Falling edge of fill_we marks the end of the filler stream.
                if ((fill_we_q && !fill_we) || (wd_q == WdWidth'(WdLimit - 1))) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Set after the IDLE clear so a pulse on the starting vsync is kept.
        if (clear_req) begin
            clr_pend_d = 1'b1;
        end
    end

    // en_q holds off host grants until the first edge after reset release.
    assign grant = en_q && (state_q == StIdle) && host_req && !ack_q && !start_op;

    always_comb begin
        host_ack = grant;
        busy     = (state_q != StIdle);
        refresh  = (state_q == StStart);
        zero_buf = ((state_q == StStart) && mode_clear_q) || (state_q == StClear);
        buf_we   = 1'b0;
        buf_x    = '0;
        buf_y    = '0;
        buf_c    = '0;
        if ((state_q == StFill) || (state_q == StClear)) begin
            buf_we = fill_we;
            buf_x  = fill_x;
            buf_y  = fill_y;
            buf_c  = fill_c;
        end else if (grant) begin
            buf_we = 1'b1;
            buf_x  = host_x;
            buf_y  = host_y;
            buf_c  = host_c;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            mode_clear_q <= 1'b0;
            fcnt_q       <= 8'd0;
            clr_pend_q   <= 1'b0;
            refill_due_q <= 1'b0;
            ack_q        <= 1'b0;
            fill_we_q    <= 1'b0;
            wd_q         <= '0;
            en_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_clear_q <= mode_clear_d;
            fcnt_q       <= fcnt_d;
            clr_pend_q   <= clr_pend_d;
            refill_due_q <= refill_due_d;
            ack_q        <= grant;
            fill_we_q    <= fill_we_d;
            wd_q         <= wd_d;
            en_q         <= 1'b1;
        end
    end

    logic unused_width;
    assign unused_width = ^{XWidth[0], YWidth[0]};

endmodule
